// File: rtl/dataselector_rr_pkg.sv
// Shared types and helpers for the parametrised data selector.
package dataselector_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    PRIO  = 2'b01,
    RR    = 2'b10,
    RSVD  = 2'b11
  } mode_e;

  // Channel index width; a single bit even when only one channel exists.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dataselector_rr_if.sv
// Request/response bundle between the channel sources, the selector and its consumer.
interface dataselector_rr_if
  import dataselector_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int CH_W     = ch_w(CHANNELS)
) ();

  // Handshake: a word moves across a side on a rising clk edge where both its
  // valid and ready are 1. Input side: in_ready[i] only rises for the granted
  // channel and may depend combinationally on out_ready. Output side: once
  // out_valid is 1, out_valid/out_data/out_ch hold until out_ready is seen.
  mode_e                      mode;
  logic [CH_W-1:0]            sel;
  logic [CHANNELS-1:0]        in_valid;
  logic [CHANNELS*WIDTH-1:0]  in_data;
  logic [CHANNELS-1:0]        in_ready;
  logic                       out_valid;
  logic [WIDTH-1:0]           out_data;
  logic [CH_W-1:0]            out_ch;
  logic                       out_ready;
  logic [CH_W-1:0]            rr_ptr;

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch, rr_ptr
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch, rr_ptr
  );

endinterface

// File: rtl/dataselector_rr_pick.sv
// Rotating find-first-set: first asserted req at or after ptr, wrapping modulo N.
module rr_pick
  import dataselector_pkg::*;
#(
  parameter int N = 4,
  localparam int W = ch_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  int j;

  always_comb begin
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = W'(j);
      end
    end
  end

endmodule

// File: rtl/dataselector_rr.sv
// Registered CHANNELS:1 data selector with fixed-select, fixed-priority and round-robin modes.
module dataselector_rr
  import dataselector_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  localparam int CH_W    = ch_w(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst_n,
  dataselector_rr_if.slave bus
);

  logic                ld;
  logic                xfer;
  logic                grant_any;
  logic [CHANNELS-1:0] fix_gnt;
  logic [CHANNELS-1:0] grant;
  logic [CHANNELS-1:0] pick_gnt;
  logic                pick_any;
  logic [CH_W-1:0]     pick_ptr;
  logic [CH_W-1:0]     pick_idx;
  logic [CH_W-1:0]     gnt_idx;
  logic [CH_W-1:0]     rr_ptr;
  logic                out_valid;
  logic [WIDTH-1:0]    out_data;
  logic [CH_W-1:0]     out_ch;

  assign ld = !out_valid || bus.out_ready;

  // Fixed priority is the rotating search anchored at channel 0.
  assign pick_ptr = (bus.mode == RR) ? rr_ptr : '0;

  rr_pick #(.N(CHANNELS)) u_pick (
    .req (bus.in_valid),
    .ptr (pick_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // An out-of-range sel matches no channel, so that channel is simply never served.
  always_comb begin
    fix_gnt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      fix_gnt[i] = bus.in_valid[i] && (bus.sel == CH_W'(i));
    end
  end

  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    gnt_idx   = '0;
    case (bus.mode)
      FIXED: begin
        grant     = fix_gnt;
        grant_any = |fix_gnt;
        gnt_idx   = bus.sel;
      end
      PRIO, RR: begin
        grant     = pick_gnt;
        grant_any = pick_any;
        gnt_idx   = pick_idx;
      end
      default: begin
        grant     = '0;
        grant_any = 1'b0;
        gnt_idx   = '0;
      end
    endcase
  end

  assign xfer         = ld && grant_any;
  assign bus.in_ready = (rst_n && ld) ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (ld) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= bus.in_data[gnt_idx*WIDTH +: WIDTH];
        out_ch   <= gnt_idx;
        if (bus.mode == RR) begin
          rr_ptr <= (gnt_idx == CH_W'(CHANNELS - 1)) ? '0 : gnt_idx + CH_W'(1);
        end
      end
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_ch    = out_ch;
  assign bus.rr_ptr    = rr_ptr;

endmodule

// File: tb/tb_dataselector_rr.sv
// Bench for dataselector_rr: directed vector table, corner sequences and random traffic vs a reference model.
module tb_dataselector_rr;
  import dataselector_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  dataselector_rr_if #(.WIDTH(4), .CHANNELS(4)) bus_a ();
  dataselector_rr_if #(.WIDTH(8), .CHANNELS(3)) bus_b ();

  dataselector_rr #(.WIDTH(4), .CHANNELS(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  dataselector_rr #(.WIDTH(8), .CHANNELS(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  int         m_valid [2];
  logic [7:0] m_data  [2];
  int         m_ch    [2];
  int         m_ptr   [2];
  logic [5:0] exp_q[$];
  logic [3:0] pre_ir_a;
  logic [2:0] pre_ir_b;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void reset_model();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 0;
      m_data[d]  = '0;
      m_ch[d]    = 0;
      m_ptr[d]   = 0;
    end
    exp_q.delete();
  endfunction

  // Channel the rules pick this cycle, or -1 for none.
  function automatic int ref_grant(int md, int s, logic [15:0] v, int ptr, int n);
    int c;
    if (md == 0) return (s < n && v[s]) ? s : -1;
    if (md == 1) begin
      for (int i = 0; i < n; i++) if (v[i]) return i;
      return -1;
    end
    if (md == 2) begin
      for (int o = 0; o < n; o++) begin
        c = (ptr + o) % n;
        if (v[c]) return c;
      end
      return -1;
    end
    return -1;
  endfunction

  function automatic void model_step(int d, logic ld, int g, logic [63:0] din, int md, int n, int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    if (ld) begin
      if (g >= 0) begin
        m_valid[d] = 1;
        m_data[d]  = 8'((din >> (g * w)) & mask);
        m_ch[d]    = g;
        if (md == 2) m_ptr[d] = (g == n - 1) ? 0 : g + 1;
        if (d == 0) exp_q.push_back({2'(g), 4'(m_data[d])});
      end else begin
        m_valid[d] = 0;
      end
    end
  endfunction

  // ---------------- driver: one clock cycle, checked against the model ----------------
  task automatic do_cycle();
    int          ga, gb, mda, mdb;
    logic        lda, ldb;
    logic [63:0] da, db;
    logic [5:0]  e;
    #2;
    mda = int'(bus_a.mode);
    mdb = int'(bus_b.mode);
    da  = 64'(bus_a.in_data);
    db  = 64'(bus_b.in_data);
    ga  = ref_grant(mda, int'(bus_a.sel), 16'(bus_a.in_valid), m_ptr[0], 4);
    gb  = ref_grant(mdb, int'(bus_b.sel), 16'(bus_b.in_valid), m_ptr[1], 3);
    lda = (m_valid[0] == 0) || bus_a.out_ready;
    ldb = (m_valid[1] == 0) || bus_b.out_ready;
    pre_ir_a = bus_a.in_ready;
    pre_ir_b = bus_b.in_ready;
    chk("a_in_ready", 32'(pre_ir_a), (lda && ga >= 0) ? (32'd1 << ga) : 32'd0);
    chk("b_in_ready", 32'(pre_ir_b), (ldb && gb >= 0) ? (32'd1 << gb) : 32'd0);
    if (bus_a.out_valid && bus_a.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("a_sb_empty", {26'd0, bus_a.out_ch, bus_a.out_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("a_sb_word", {26'd0, bus_a.out_ch, bus_a.out_data}, 32'(e));
      end
    end
    @(posedge clk);
    model_step(0, lda, ga, da, mda, 4, 4);
    model_step(1, ldb, gb, db, mdb, 3, 8);
    #1;
    chk("a_out_valid", 32'(bus_a.out_valid), 32'(m_valid[0]));
    chk("a_out_data",  32'(bus_a.out_data),  32'(m_data[0][3:0]));
    chk("a_out_ch",    32'(bus_a.out_ch),    32'(m_ch[0]));
    chk("a_rr_ptr",    32'(bus_a.rr_ptr),    32'(m_ptr[0]));
    chk("b_out_valid", 32'(bus_b.out_valid), 32'(m_valid[1]));
    chk("b_out_data",  32'(bus_b.out_data),  32'(m_data[1]));
    chk("b_out_ch",    32'(bus_b.out_ch),    32'(m_ch[1]));
    chk("b_rr_ptr",    32'(bus_b.rr_ptr),    32'(m_ptr[1]));
  endtask

  task automatic drive_a(mode_e md, logic [1:0] s, logic [3:0] v, logic [15:0] d, logic r);
    bus_a.mode      = md;
    bus_a.sel       = s;
    bus_a.in_valid  = v;
    bus_a.in_data   = d;
    bus_a.out_ready = r;
  endtask

  task automatic drive_b(mode_e md, logic [1:0] s, logic [2:0] v, logic [23:0] d, logic r);
    bus_b.mode      = md;
    bus_b.sel       = s;
    bus_b.in_valid  = v;
    bus_b.in_data   = d;
    bus_b.out_ready = r;
  endtask

  // ---------------- directed vectors for the 4x4 instance ----------------
  typedef struct {
    mode_e       mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic [15:0] data;
    logic        ready;
    logic [3:0]  exp_ir;
    logic        exp_v;
    logic [3:0]  exp_d;
    logic [1:0]  exp_ch;
    logic [1:0]  exp_ptr;
  } vec_t;

  vec_t tbl [19];
  logic [7:0] b_seq_data [4];
  int         b_seq_ch   [4];

  initial begin
    checks = 0;
    errors = 0;
    tbl[0]  = '{FIXED, 2'd2, 4'b1111, 16'hDCBA, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2, 2'd0};
    tbl[1]  = '{FIXED, 2'd3, 4'b1111, 16'hDCBA, 1'b1, 4'b1000, 1'b1, 4'hD, 2'd3, 2'd0};
    tbl[2]  = '{PRIO,  2'd0, 4'b1010, 16'hDCBA, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1, 2'd0};
    tbl[3]  = '{PRIO,  2'd0, 4'b1000, 16'hDCBA, 1'b1, 4'b1000, 1'b1, 4'hD, 2'd3, 2'd0};
    tbl[4]  = '{PRIO,  2'd0, 4'b0000, 16'hDCBA, 1'b1, 4'b0000, 1'b0, 4'hD, 2'd3, 2'd0};
    tbl[5]  = '{RR,    2'd0, 4'b1111, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0, 2'd1};
    tbl[6]  = '{RR,    2'd0, 4'b1111, 16'hDCBA, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1, 2'd2};
    tbl[7]  = '{RR,    2'd0, 4'b1111, 16'hDCBA, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2, 2'd3};
    tbl[8]  = '{RR,    2'd0, 4'b1111, 16'hDCBA, 1'b1, 4'b1000, 1'b1, 4'hD, 2'd3, 2'd0};
    tbl[9]  = '{RR,    2'd0, 4'b1111, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0, 2'd1};
    tbl[10] = '{RR,    2'd0, 4'b1111, 16'hDCBA, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1, 2'd2};
    tbl[11] = '{RR,    2'd0, 4'b1001, 16'hDCBA, 1'b1, 4'b1000, 1'b1, 4'hD, 2'd3, 2'd0};
    tbl[12] = '{RR,    2'd0, 4'b1001, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0, 2'd1};
    tbl[13] = '{RR,    2'd0, 4'b0010, 16'hDC5A, 1'b1, 4'b0010, 1'b1, 4'h5, 2'd1, 2'd2};
    tbl[14] = '{RR,    2'd0, 4'b1111, 16'hDC5A, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd1, 2'd2};
    tbl[15] = '{RR,    2'd0, 4'b1111, 16'hDC5A, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd1, 2'd2};
    tbl[16] = '{RR,    2'd0, 4'b1111, 16'hDC5A, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd1, 2'd2};
    tbl[17] = '{RR,    2'd0, 4'b1111, 16'hDC5A, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2, 2'd3};
    tbl[18] = '{RSVD,  2'd0, 4'b1111, 16'hDC5A, 1'b1, 4'b0000, 1'b0, 4'hC, 2'd2, 2'd3};
    b_seq_data = '{8'h11, 8'h22, 8'h33, 8'h11};
    b_seq_ch   = '{0, 1, 2, 0};

    // Reset with every channel requesting and the consumer ready.
    rst_n = 1'b0;
    drive_a(FIXED, 2'd2, 4'b1111, 16'hDCBA, 1'b1);
    drive_b(FIXED, 2'd0, 3'b111, 24'h332211, 1'b1);
    reset_model();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_a_in_ready",  32'(bus_a.in_ready),  32'd0);
    chk("rst_a_out_valid", 32'(bus_a.out_valid), 32'd0);
    chk("rst_a_out_data",  32'(bus_a.out_data),  32'd0);
    chk("rst_a_out_ch",    32'(bus_a.out_ch),    32'd0);
    chk("rst_a_rr_ptr",    32'(bus_a.rr_ptr),    32'd0);
    chk("rst_b_in_ready",  32'(bus_b.in_ready),  32'd0);
    chk("rst_b_out_valid", 32'(bus_b.out_valid), 32'd0);
    rst_n = 1'b1;
    drive_b(FIXED, 2'd0, 3'b000, 24'h0, 1'b1);

    for (int i = 0; i < 19; i++) begin
      drive_a(tbl[i].mode, tbl[i].sel, tbl[i].valid, tbl[i].data, tbl[i].ready);
      do_cycle();
      chk($sformatf("tbl%0d_in_ready", i),  32'(pre_ir_a),        32'(tbl[i].exp_ir));
      chk($sformatf("tbl%0d_out_valid", i), 32'(bus_a.out_valid), 32'(tbl[i].exp_v));
      chk($sformatf("tbl%0d_out_data", i),  32'(bus_a.out_data),  32'(tbl[i].exp_d));
      chk($sformatf("tbl%0d_out_ch", i),    32'(bus_a.out_ch),    32'(tbl[i].exp_ch));
      chk($sformatf("tbl%0d_rr_ptr", i),    32'(bus_a.rr_ptr),    32'(tbl[i].exp_ptr));
    end

    // Three-channel instance: round-robin wraps after channel 2.
    drive_a(FIXED, 2'd0, 4'b0000, 16'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive_b(RR, 2'd0, 3'b111, 24'h332211, 1'b1);
      do_cycle();
      chk($sformatf("b_rr%0d_out_ch", i),   32'(bus_b.out_ch),   32'(b_seq_ch[i]));
      chk($sformatf("b_rr%0d_out_data", i), 32'(bus_b.out_data), 32'(b_seq_data[i]));
    end
    // sel beyond the last channel is never served.
    for (int i = 0; i < 2; i++) begin
      drive_b(FIXED, 2'd3, 3'b111, 24'h332211, 1'b1);
      do_cycle();
      chk("b_sel3_in_ready",  32'(pre_ir_b),        32'd0);
      chk("b_sel3_out_valid", 32'(bus_b.out_valid), 32'd0);
    end

    // Reset while a word is held under back-pressure.
    drive_b(FIXED, 2'd0, 3'b000, 24'h0, 1'b1);
    drive_a(RR, 2'd0, 4'b1111, 16'h9876, 1'b0);
    do_cycle();
    do_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    reset_model();
    chk("midrst_out_valid", 32'(bus_a.out_valid), 32'd0);
    chk("midrst_out_data",  32'(bus_a.out_data),  32'd0);
    chk("midrst_rr_ptr",    32'(bus_a.rr_ptr),    32'd0);
    chk("midrst_in_ready",  32'(bus_a.in_ready),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic on both instances.
    for (int n = 0; n < 600; n++) begin
      drive_a(($urandom_range(0, 9) < 5) ? RR : mode_e'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 4'($urandom), 16'($urandom),
              $urandom_range(0, 3) != 0);
      drive_b(($urandom_range(0, 9) < 5) ? RR : mode_e'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 3'($urandom), 24'($urandom),
              $urandom_range(0, 3) != 0);
      do_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dataselector_rr.md
Name: dataselector_rr

Overview:
- Parametrised successor to the minicpu 4:1 data selector.
- Selects one of CHANNELS request channels, each WIDTH bits wide, using one of three runtime modes: fixed-select, fixed-priority or round-robin.
- Output is registered and uses a valid/ready handshake, so operand/bus sources with back-pressure share one downstream consumer.
- Sits between register-file/immediate/IO sources and the ALU or output-port write path.

Parameters:
- WIDTH, 4, data width per channel (>=1).
- CHANNELS, 4, number of input channels (2..16).
- CH_W, max(1,$clog2(CHANNELS)), derived width of channel index; not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2  arbitration mode (package enum: FIXED=00, PRIO=01, RR=10, reserved 11).
- sel  in  CH_W  channel index used in FIXED mode.
- in_valid  in  CHANNELS  per-channel valid.
- in_data  in  CHANNELS*WIDTH  packed data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  CHANNELS  per-channel ready (combinational).
- out_valid  out  1  registered output valid.
- out_data  out  WIDTH  registered selected data.
- out_ch  out  CH_W  index of the channel that supplied out_data.
- out_ready  in  1  downstream ready.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
  - in_ready is 0 for all channels while rst_n=0.
- Load enable: ld = !out_valid || out_ready.
- Grant vector (one-hot or zero), combinational from in_valid, mode, sel, rr_ptr:
  - FIXED: grant[sel]=in_valid[sel]. If sel>=CHANNELS, grant=0 (channel never served, no error).
  - PRIO: lowest-index valid channel.
  - RR: first valid channel searching rr_ptr, rr_ptr+1, ..., wrapping modulo CHANNELS.
  - Reserved mode 11: grant=0.
- in_ready[i] = ld && grant[i]. Transfer on channel i iff in_valid[i] && in_ready[i]. At most one transfer per cycle.
- On a clock edge with ld=1:
  - A transfer on k loads out_valid=1, out_data=in_data[k], out_ch=k.
  - No transfer loads out_valid=0. out_data/out_ch hold their last value.
- With out_valid=1 and out_ready=0: out_valid, out_data and out_ch hold stable. in_ready is all 0.
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 word/cycle with out_ready held high. The output is consumed and refilled on the same edge.
- rr_ptr:
  - Updates only on a transfer while mode=RR: rr_ptr <= (k==CHANNELS-1) ? 0 : k+1.
  - Unchanged in other modes and on idle cycles.
- Mode/sel changes take effect on the next grant evaluation. A word already held in the output register is unaffected.
- in_valid may drop without a transfer (no input-side protocol checking). The output side obeys valid/ready: once raised, out_valid stays high until out_ready.
- Reset mid-transfer: the held word is discarded, rr_ptr returns to 0, and no partial state survives.
- No combinational path from in_valid/in_data to out_*. out_ready reaches in_ready combinationally (documented, acceptable).

Decomposition:
- Package dataselector_pkg:
  - mode_e enum (FIXED, PRIO, RR, RSVD).
  - Localparam helper function for CH_W.
- Sub-module rr_pick (params N):
  - Inputs: req[N], ptr[$clog2(N)].
  - Outputs: one-hot gnt[N], idx, any.
  - Behaviour: rotating find-first-set.
  - PRIO mode reuses it with ptr=0.
- Grant muxing, output register and rr_ptr live in the top module.

Test Plan:
- Reset: hold rst_n=0 with in_valid=4'b1111, out_ready=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0. Release; next edge -> out_valid=1.
- FIXED, sel=2, in_data={4'hD,4'hC,4'hB,4'hA}, in_valid=1111, out_ready=1 -> in_ready=0100. One cycle later out_data=4'hC, out_ch=2. sel=3 -> 4'hD next.
- PRIO, in_valid=1010 -> out_ch=1, then ch1 drops -> out_ch=3. in_valid=0000 -> out_valid=0 after the edge.
- RR, all valid, out_ready=1 for 6 cycles -> out_ch sequence 0,1,2,3,0,1. Then in_valid=1001 with rr_ptr=2 -> grant ch3, then ch0.
- Back-pressure: out_valid=1, out_data=4'h5, out_ready=0 for 3 cycles -> out_data/out_ch stable, in_ready=0, rr_ptr unchanged. out_ready=1 -> new word loads the same edge.
- Parameter sweep WIDTH=8, CHANNELS=3, RR, all valid -> wrap 0,1,2,0. FIXED sel=3 -> in_ready=000, out_valid stays 0.
